aqed_fifo_checker: RTL
======================

# aqed_fifo_checker

Parametrised A-QED monitor for FIFO-mode memory cores with multiple channels. It captures one original write and its first matching duplicate on a selected channel, then pairs the corresponding FIFO outputs by stream index. It reports functional consistency (`qed_done`/`qed_check`) and a response-bound violation. It is instantiated beside the DUT inside formal harness tops, replacing the single-channel fixed-width checker.

## Interface
Parameters:
- `DATA_W`, 16: data width per channel.
- `NUM_CH`, 2: number of monitored FIFO channels.
- `CNT_W`, 17: width of the write/read index counters.
- `BOUND_MULT`, 4: response bound, in multiples of `depth`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clk_en` in 1: when 0, all state holds.
- `depth` in 16: configured FIFO depth. Held constant by the harness, must be nonzero.
- `ch_sel` in $clog2(NUM_CH): channel under check. Sampled only at original capture.
- `exec_orig` in 1: marks the current write on `ch_sel` as the original.
- `exec_dup` in 1: marks the current write as the duplicate candidate.
- `wen` in NUM_CH: per-channel write accepted.
- `din` in NUM_CH*DATA_W: per-channel write data, channel i at bits [i*DATA_W +: DATA_W].
- `ren` in NUM_CH: per-channel read strobe.
- `valid_out` in NUM_CH: per-channel output valid.
- `dout` in NUM_CH*DATA_W: per-channel output data.
- `orig_issued` out 1: original captured.
- `orig_done` out 1: original's output observed.
- `qed_done` out 1: duplicate's output observed.
- `qed_check` out 1: outputs of original and duplicate are equal. Meaningful only when `qed_done`=1.
- `bound_fail` out 1: response-bound violation (sticky).

## Operation
- Per-channel counters: `wr_cnt[i]` and `rd_cnt[i]`.
  - `wr_cnt[i]` increments on `wen[i]`.
  - `rd_cnt[i]` increments on `ren[i]&valid_out[i]` (a "read").
  - Counters saturate at 2^CNT_W-1.
- FSM states: IDLE, ORIG, DUP, DONE.
- IDLE → ORIG: `exec_orig & wen[ch_sel]`. Latch the following:
  - `ch_q=ch_sel`
  - `orig_data=din[ch_sel]`
  - `orig_idx=wr_cnt[ch_sel]` (pre-increment value)
- ORIG → DUP: `exec_dup & wen[ch_q] & din[ch_q]==orig_data`.
  - Latch `dup_idx=wr_cnt[ch_q]`.
  - A duplicate candidate with non-matching data is ignored and the FSM stays in ORIG.
- Output capture on a read of `ch_q`:
  - If `rd_cnt[ch_q]==orig_idx` in ORIG or DUP: latch `orig_out=dout[ch_q]` and set `orig_done`.
  - If in DUP and `rd_cnt[ch_q]==dup_idx`: latch `dup_out`, go to DONE.
- DONE is terminal until reset.
  - `qed_done`=1.
  - `qed_check=(orig_out==dup_out)`.
- Response bound:
  - `post_rd` counts reads on `ch_q` while the FSM is not IDLE. It saturates.
  - `bound_fail` is set when `post_rd >= BOUND_MULT*depth` and `orig_done`=0.
  - The product is computed at CNT_W+2 bits, with no truncation.
- Reads and writes on other channels only advance their own counters.

## Timing
- Reset values: all outputs 0, FSM IDLE, all counters and latches 0.
- All outputs are registered. A capture event at edge N is visible after edge N.
- `orig_done` and `qed_done` are sticky.
- Same-cycle read and write on `ch_q` both count.
- A capture compares against the pre-increment counter value.
- The original's write and its read in the same cycle cannot collide. The read index always lags.
- `exec_orig` outside IDLE is ignored. `exec_dup` in IDLE is ignored.
- `clk_en`=0 freezes counters, FSM, latches and `bound_fail`. Outputs hold.
- Reset asserted mid-operation clears everything immediately (asynchronously).
- Saturated counters stop comparing: no spurious index match after wrap.

## Structure
- Package `aqed_pkg`: FSM state enum `aqed_state_e` (IDLE, ORIG, DUP, DONE) and default-parameter constants.
- Sub-module `aqed_idx_counter`:
  - Parametrised by CNT_W, with saturation, `clk_en` and increment.
  - Instantiated 2*NUM_CH+1 times: write, read and `post_rd` counters.
- Top holds the FSM, latches, comparators and bound logic.

## Test plan
- Channel 0, depth=4: write A0..A3, orig at A1 (`orig_idx`=1), dup `din`=A1 at index 3. Read all four in order → `orig_done` on the 2nd read, then `qed_done`=1 and `qed_check`=1 on the 4th read.
- Same sequence, but the DUT output for index 3 is corrupted to 0xDEAD → `qed_done`=1, `qed_check`=0.
- Orig on channel 1 with interleaved traffic on channel 0 → channel 0 traffic never changes the FSM. Check result is correct on channel 1.
- depth=2, `BOUND_MULT`=4: orig issued, DUT never returns the orig index, 8 reads → `bound_fail` rises after the 8th read and stays high.
- Dup with non-matching data, then a matching dup → only the second is latched (`dup_idx` = its write index).
- Assert reset while in DUP and drop `clk_en` for 3 cycles → immediate all-zero outputs. No counter advances while `clk_en`=0.

Source files
------------

// File: rtl/aqed_fifo_checker_pkg.sv
// -----------------------------------------------------------------------------
// aqed_pkg
// Shared types and default constants for the A-QED FIFO checker.
//   aqed_state_e : checker FSM states (IDLE, ORIG, DUP, DONE)
//   DEF_*        : default parameter values used by the top
//   ch_w()       : width of a channel selector, never less than 1 bit
// -----------------------------------------------------------------------------
package aqed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ORIG = 2'd1,
        DUP  = 2'd2,
        DONE = 2'd3
    } aqed_state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_CNT_W      = 17;
    localparam int DEF_BOUND_MULT = 4;
    localparam int DEPTH_W        = 16;

    // A single-channel build still needs a 1-bit selector port.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/aqed_fifo_checker_idx_counter.sv
// -----------------------------------------------------------------------------
// aqed_idx_counter
// Saturating up-counter used for the per-channel write/read stream indices and
// for the post-issue read count.
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous active-low reset
//   clk_en in  : when 0 the count holds
//   inc    in  : advance by one (ignored once saturated)
//   cnt    out : current count, sticks at 2^CNT_W-1
// -----------------------------------------------------------------------------
module aqed_idx_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clk_en && inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/aqed_fifo_checker.sv
// -----------------------------------------------------------------------------
// aqed_fifo_checker
// A-QED monitor for multi-channel FIFO-mode memory cores. It captures one
// original write and its first data-matching duplicate on a selected channel,
// pairs their FIFO outputs by stream index and reports whether they agree.
// It also flags a response-bound violation when the original's output does
// not appear within BOUND_MULT*depth reads.
// Ports:
//   clk, reset        : clock (rising) and asynchronous active-low reset
//   clk_en            : global enable, 0 freezes all state
//   depth             : configured FIFO depth (constant, nonzero)
//   ch_sel            : channel under check, sampled at original capture
//   exec_orig/dup     : mark the current write as original / duplicate
//   wen, din          : per-channel write strobe and data
//   ren, valid_out,
//   dout              : per-channel read strobe, output valid, output data
//   orig_issued       : original captured
//   orig_done         : original's output observed (sticky)
//   qed_done          : duplicate's output observed (sticky)
//   qed_check         : original and duplicate outputs are equal
//   bound_fail        : response-bound violation (sticky)
//   dbg_state         : current FSM state for external checkers
// -----------------------------------------------------------------------------
module aqed_fifo_checker
    import aqed_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int BOUND_MULT = DEF_BOUND_MULT,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic [DEPTH_W-1:0]       depth,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     exec_orig,
    input  logic                     exec_dup,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic [NUM_CH-1:0]        ren,
    input  logic [NUM_CH-1:0]        valid_out,
    input  logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     orig_issued,
    output logic                     orig_done,
    output logic                     qed_done,
    output logic                     qed_check,
    output logic                     bound_fail,
    output logic [1:0]               dbg_state
);

    // Handshake semantics: there is no back-pressure. A write on channel i is
    // accepted whenever wen[i]=1 (din sampled that cycle); a read happens only
    // when ren[i] and valid_out[i] are both 1 (dout sampled that cycle). Each
    // accepted write/read consumes exactly one stream index on its channel.

    localparam int               PROD_W  = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ---------------------------------------------------------------- counters
    logic [NUM_CH-1:0] rd_fire;
    logic [CNT_W-1:0]  wr_cnt [NUM_CH];
    logic [CNT_W-1:0]  rd_cnt [NUM_CH];
    logic [CNT_W-1:0]  post_rd;
    logic              post_inc;

    assign rd_fire = ren & valid_out;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        aqed_idx_counter #(.CNT_W(CNT_W)) u_wr_cnt (
            .clk    (clk),
            .reset  (reset),
            .clk_en (clk_en),
            .inc    (wen[g]),
            .cnt    (wr_cnt[g])
        );
        aqed_idx_counter #(.CNT_W(CNT_W)) u_rd_cnt (
            .clk    (clk),
            .reset  (reset),
            .clk_en (clk_en),
            .inc    (rd_fire[g]),
            .cnt    (rd_cnt[g])
        );
    end

    aqed_idx_counter #(.CNT_W(CNT_W)) u_post_rd_cnt (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .inc    (post_inc),
        .cnt    (post_rd)
    );

    // ------------------------------------------------------------------ state
    aqed_state_e       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] orig_data_q, orig_data_d;
    logic [CNT_W-1:0]  orig_idx_q, orig_idx_d;
    logic [CNT_W-1:0]  dup_idx_q, dup_idx_d;
    logic [DATA_W-1:0] orig_out_q, orig_out_d;
    logic [DATA_W-1:0] dup_out_q, dup_out_d;
    logic              orig_issued_q, orig_issued_d;
    logic              orig_done_q, orig_done_d;
    logic              qed_done_q, qed_done_d;
    logic              bound_fail_q, bound_fail_d;

    // -------------------------------------------------------- channel muxing
    // "sel_*" views the channel named by ch_sel (used only for capture);
    // "q_*" views the latched channel under check.
    logic              sel_wen;
    logic [DATA_W-1:0] sel_din;
    logic [CNT_W-1:0]  sel_wr_cnt;
    logic              q_wen;
    logic [DATA_W-1:0] q_din;
    logic [CNT_W-1:0]  q_wr_cnt;
    logic              q_rd_fire;
    logic [CNT_W-1:0]  q_rd_cnt;
    logic [DATA_W-1:0] q_dout;

    always_comb begin
        sel_wen    = 1'b0;
        sel_din    = '0;
        sel_wr_cnt = '0;
        q_wen      = 1'b0;
        q_din      = '0;
        q_wr_cnt   = '0;
        q_rd_fire  = 1'b0;
        q_rd_cnt   = '0;
        q_dout     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                sel_wen    = wen[i];
                sel_din    = din[i*DATA_W +: DATA_W];
                sel_wr_cnt = wr_cnt[i];
            end
            if (ch_q == CH_W'(i)) begin
                q_wen     = wen[i];
                q_din     = din[i*DATA_W +: DATA_W];
                q_wr_cnt  = wr_cnt[i];
                q_rd_fire = rd_fire[i];
                q_rd_cnt  = rd_cnt[i];
                q_dout    = dout[i*DATA_W +: DATA_W];
            end
        end
    end

    // A read counter stuck at its maximum no longer tracks real stream
    // positions, so it is never allowed to produce an index match.
    logic orig_match;
    logic dup_match;

    assign orig_match = q_rd_fire && (q_rd_cnt != CNT_MAX) && (q_rd_cnt == orig_idx_q);
    assign dup_match  = q_rd_fire && (q_rd_cnt != CNT_MAX) && (q_rd_cnt == dup_idx_q);

    // ------------------------------------------------------------ bound logic
    // The bound is evaluated against the post-increment read count so that the
    // violation is visible right after the read that crosses the limit.
    logic [CNT_W-1:0]  post_rd_next;
    logic [PROD_W-1:0] bound_lim;

    assign post_inc     = q_rd_fire && (state_q != IDLE);
    assign post_rd_next = (clk_en && post_inc && (post_rd != CNT_MAX)) ?
                          (post_rd + CNT_ONE) : post_rd;
    assign bound_lim    = PROD_W'(BOUND_MULT) * PROD_W'(depth);

    // -------------------------------------------------------- next-state FSM
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        orig_data_d   = orig_data_q;
        orig_idx_d    = orig_idx_q;
        dup_idx_d     = dup_idx_q;
        orig_out_d    = orig_out_q;
        dup_out_d     = dup_out_q;
        orig_issued_d = orig_issued_q;
        orig_done_d   = orig_done_q;
        qed_done_d    = qed_done_q;
        bound_fail_d  = bound_fail_q;

        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (exec_orig && sel_wen) begin
                        state_d       = ORIG;
                        ch_d          = ch_sel;
                        orig_data_d   = sel_din;
                        orig_idx_d    = sel_wr_cnt;
                        orig_issued_d = 1'b1;
                    end
                end
                ORIG: begin
                    // A duplicate with different data is not a duplicate.
                    if (exec_dup && q_wen && (q_din == orig_data_q)) begin
                        state_d   = DUP;
                        dup_idx_d = q_wr_cnt;
                    end
                end
                DUP: begin
                    if (dup_match) begin
                        state_d    = DONE;
                        dup_out_d  = q_dout;
                        qed_done_d = 1'b1;
                    end
                end
                default: begin
                    // DONE holds until reset.
                end
            endcase

            // The original's output can arrive before or after the duplicate
            // is captured; it is latched once.
            if (((state_q == ORIG) || (state_q == DUP)) && orig_match && !orig_done_q) begin
                orig_out_d  = q_dout;
                orig_done_d = 1'b1;
            end

            if ((state_q != IDLE) && !orig_done_d &&
                ({2'b00, post_rd_next} >= bound_lim)) begin
                bound_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            orig_data_q   <= '0;
            orig_idx_q    <= '0;
            dup_idx_q     <= '0;
            orig_out_q    <= '0;
            dup_out_q     <= '0;
            orig_issued_q <= 1'b0;
            orig_done_q   <= 1'b0;
            qed_done_q    <= 1'b0;
            bound_fail_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            orig_data_q   <= orig_data_d;
            orig_idx_q    <= orig_idx_d;
            dup_idx_q     <= dup_idx_d;
            orig_out_q    <= orig_out_d;
            dup_out_q     <= dup_out_d;
            orig_issued_q <= orig_issued_d;
            orig_done_q   <= orig_done_d;
            qed_done_q    <= qed_done_d;
            bound_fail_q  <= bound_fail_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign orig_issued = orig_issued_q;
    assign orig_done   = orig_done_q;
    assign qed_done    = qed_done_q;
    // Derived purely from registers; gated so it reads 0 until the pair exists.
    assign qed_check   = qed_done_q && (orig_out_q == dup_out_q);
    assign bound_fail  = bound_fail_q;
    assign dbg_state   = state_q;

endmodule
